key_debounce: RTL and testbench

- Input conditioner for the board's 4 switches and 4 push-keys, sitting directly upstream of the onboard I/O register block.
- Synchronises raw pad levels and debounces each bit with a shared prescaled tick.
- Drives clean levels into the I/O block's switches/keys inputs.
- Also produces per-bit edge pulses, sticky change flags and a maskable change interrupt.

---
 rtl/key_debounce.sv | 83 ++++++++
 tb/tb_key_debounce.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Input conditioner for board switches and keys: two-flop synchroniser, tick-based
// debounce per bit, edge pulses, sticky change flags and a maskable change interrupt.
module key_debounce #(
  parameter int unsigned  N        = 8,
  parameter int unsigned  PRESCALE = 1000,
  parameter int unsigned  DB_TICKS = 20,
  parameter int unsigned  CNT_W    = 8,
  parameter logic [N-1:0] INIT     = {N{1'b1}}
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] clean,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] changed,
  input  logic [N-1:0] clr,
  input  logic [N-1:0] irq_mask,
  output logic         irq
);

  localparam int unsigned      PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PreMax = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_TICKS - 1);

  logic [N-1:0]            sync1, sync2;
  logic [PW-1:0]           presc_q, presc_d;
  logic                    tick;
  logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]            commit, clean_d, changed_d;

  assign tick    = (presc_q == PreMax);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // A bit whose synchronised level agrees with clean holds its counter at zero, so any
  // single-cycle agreement restarts the settle from scratch.
  always_comb begin
    cnt_d   = '0;
    commit  = '0;
    clean_d = clean;
    for (int i = 0; i < N; i++) begin
      if (sync2[i] != clean[i]) begin
        cnt_d[i] = cnt_q[i];
        if (tick) begin
          if (cnt_q[i] == CntMax) begin
            commit[i]  = 1'b1;
            clean_d[i] = sync2[i];
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end
    end
    // Set wins over a coincident clear.
    changed_d = (changed & ~clr) | commit;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1   <= INIT;
      sync2   <= INIT;
      presc_q <= '0;
      cnt_q   <= '0;
      clean   <= INIT;
      rise    <= '0;
      fall    <= '0;
      changed <= '0;
      irq     <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      clean   <= clean_d;
      rise    <= commit & sync2;
      fall    <= commit & ~sync2;
      changed <= changed_d;
      irq     <= |(changed_d & irq_mask);
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus randomized bouncing, all checked every
// cycle against a run-length/tick-count model of the debounce rules.
module tb_key_debounce;

  localparam int unsigned P    = 4;
  localparam int unsigned DB   = 3;
  localparam logic [7:0]  INIV = 8'hFF;

  logic       clk_in   = 1'b0;
  logic       rst      = 1'b1;
  logic [7:0] raw      = 8'hFF;
  logic [7:0] clr      = 8'h00;
  logic [7:0] irq_mask = 8'h00;
  logic [7:0] clean, rise, fall, changed;
  logic       irq;

  always #5 clk_in = ~clk_in;

  key_debounce #(
    .N       (8),
    .PRESCALE(P),
    .DB_TICKS(DB),
    .CNT_W   (2),
    .INIT    (INIV)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .raw     (raw),
    .clean   (clean),
    .rise    (rise),
    .fall    (fall),
    .changed (changed),
    .clr     (clr),
    .irq_mask(irq_mask),
    .irq     (irq)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: t counts cycles since reset release, ticks fall on t%P == P-1. A bit commits on
  // the cycle its current mismatch run has seen DB ticks.
  logic [7:0] m_s1 = INIV, m_s2 = INIV, m_clean = INIV;
  logic [7:0] m_rise = '0, m_fall = '0, m_changed = '0;
  logic       m_irq = 1'b0;
  int         t = 0;
  int         run_start[8];
  bit   [7:0] run_active = '0;

  task automatic model_step();
    logic [7:0] commit;
    bit         tk;
    if (rst) begin
      m_s1 = INIV; m_s2 = INIV; m_clean = INIV;
      m_rise = '0; m_fall = '0; m_changed = '0; m_irq = 1'b0;
      t = 0; run_active = '0;
      return;
    end
    tk     = ((t % P) == P - 1);
    commit = '0;
    for (int i = 0; i < 8; i++) begin
      if (m_s2[i] == m_clean[i]) begin
        run_active[i] = 1'b0;
      end else begin
        if (!run_active[i]) begin
          run_active[i] = 1'b1;
          run_start[i]  = t;
        end
        if (tk && (((t + 1) / P) - (run_start[i] / P)) == DB) begin
          commit[i]     = 1'b1;
          run_active[i] = 1'b0;
        end
      end
    end
    m_clean   = m_clean ^ commit;
    m_rise    = commit & m_clean;
    m_fall    = commit & ~m_clean;
    m_changed = (m_changed & ~clr) | commit;
    m_irq     = |(m_changed & irq_mask);
    m_s2      = m_s1;
    m_s1      = raw;
    t++;
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  initial forever begin
    @(negedge clk_in);
    if (chk_en) begin
      check("clean",   32'(clean),   32'(m_clean));
      check("rise",    32'(rise),    32'(m_rise));
      check("fall",    32'(fall),    32'(m_fall));
      check("changed", 32'(changed), 32'(m_changed));
      check("irq",     32'(irq),     32'(m_irq));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Edges until clean[b]==v, or -1 once the budget expires.
  task automatic wait_clean(input int b, input logic v, input int maxc, output int n);
    n = -1;
    for (int k = 1; k <= maxc; k++) begin
      step(1);
      if (clean[b] === v) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int bad;
    step(2);
    chk_en = 1'b1;
    rst    = 1'b0;
    check("reset_clean",   32'(clean),   32'hFF);
    check("reset_changed", 32'(changed), 32'h00);
    check("reset_irq",     32'(irq),     32'h0);

    // 1: single key press
    irq_mask = 8'h01;
    raw[0]   = 1'b0;
    wait_clean(0, 1'b0, 30, n);
    check("t1_latency_11_14", 32'(n >= 11 && n <= 14), 32'h1);
    check("t1_fall",     32'(fall),       32'h01);
    check("t1_changed0", 32'(changed[0]), 32'h1);
    check("t1_irq",      32'(irq),        32'h1);
    step(1);
    check("t1_fall_one_cycle", 32'(fall), 32'h00);
    irq_mask = 8'h00;
    step(1);
    check("t1_irq_masked", 32'(irq), 32'h0);

    // 2: bouncing key
    bad = 0;
    for (int r = 0; r < 5; r++) begin
      raw[1] = 1'b0;
      for (int k = 0; k < 7; k++) begin
        step(1);
        if (clean[1] !== 1'b1 || fall[1] || rise[1]) bad++;
      end
      raw[1] = 1'b1;
      step(1);
      if (clean[1] !== 1'b1 || fall[1] || rise[1]) bad++;
    end
    raw[1] = 1'b0;
    wait_clean(1, 1'b0, 30, n);
    check("t2_bounce_held",   32'(bad), 32'h0);
    check("t2_latency_11_14", 32'(n >= 11 && n <= 14), 32'h1);
    check("t2_fall",          32'(fall[1]), 32'h1);

    // 3: glitch shorter than the debounce window
    bad    = 0;
    raw[2] = 1'b0;
    step(3);
    raw[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (clean[2] !== 1'b1 || rise[2] || fall[2] || changed[2]) bad++;
    end
    check("t3_glitch_ignored", 32'(bad), 32'h0);

    // 4: all switches low together
    raw = 8'hFF;
    step(20);
    clr = 8'hFF;
    step(1);
    clr = 8'h00;
    raw = 8'h0F;
    wait_clean(7, 1'b0, 30, n);
    check("t4_clean",   32'(clean),   32'h0F);
    check("t4_fall",    32'(fall),    32'hF0);
    check("t4_rise",    32'(rise),    32'h00);
    check("t4_changed", 32'(changed), 32'hF0);
    clr = 8'h30;
    step(1);
    clr = 8'h00;
    check("t4_clr", 32'(changed), 32'hC0);

    // 5: commit coinciding with clear
    raw[3] = 1'b0;
    step(20);
    clr = 8'hFF;
    step(1);
    clr    = 8'h00;
    raw[3] = 1'b1;
    clr[3] = 1'b1;
    n = -1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (rise[3] === 1'b1) begin
        n = k;
        break;
      end
    end
    clr = 8'h00;
    check("t5_latency_11_14", 32'(n >= 11 && n <= 14), 32'h1);
    check("t5_set_wins",      32'(changed[3]), 32'h1);
    check("t5_irq_masked",    32'(irq), 32'h0);
    step(1);
    check("t5_sticky", 32'(changed[3]), 32'h1);
    clr[3] = 1'b1;
    step(1);
    clr = 8'h00;
    check("t5_cleared", 32'(changed[3]), 32'h0);

    // 6: reset mid-settle
    raw = 8'hFF;
    step(20);
    raw[4] = 1'b0;
    step(10);
    check("t6_still_settling", 32'(clean[4]), 32'h1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_rst_clean",   32'(clean),   32'hFF);
    check("t6_rst_changed", 32'(changed), 32'h00);
    check("t6_rst_irq",     32'(irq),     32'h0);
    wait_clean(4, 1'b0, 30, n);
    check("t6_latency_11_14", 32'(n >= 11 && n <= 14), 32'h1);

    // Randomized bouncing with random clears, masks and occasional resets
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 29) == 0) raw[b] = ~raw[b];
      clr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 99) == 0) irq_mask = 8'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      step(1);
    end
    rst = 1'b0;
    clr = 8'h00;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
